// File: rtl/battleship_turn_ctrl_if.sv
// Command/response link between the turn controller and the board datapath.
// The controller drives commands as master; the board answers with a one-cycle response strobe.
interface battleship_turn_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic       cmd_player;
    logic [1:0] cmd_x;
    logic [1:0] cmd_y;
    logic       rsp_valid;
    logic [1:0] rsp_code;

    modport master (
        output cmd_valid, cmd_op, cmd_player, cmd_x, cmd_y,
        input  cmd_ready, rsp_valid, rsp_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_player, cmd_x, cmd_y,
        output cmd_ready, rsp_valid, rsp_code
    );
endinterface

// File: rtl/battleship_turn_ctrl.sv
// Battleship game sequencer: button edge detection, turn/phase FSM, timed holds,
// place/shoot command issue to the board and score tracking up to a win.
module battleship_turn_ctrl #(
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned SHIPS       = 4,
    parameter int unsigned WIN_SCORE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    battleship_turn_ctrl_if.master bus,
    input  logic                  start_i,
    input  logic [1:0]            x_i,
    input  logic [1:0]            y_i,
    input  logic                  pAb_i,
    input  logic                  pBb_i,
    output logic [2:0]            phase_o,
    output logic                  battle_o,
    output logic                  turn_o,
    output logic [2:0]            placeCnt_o,
    output logic [2:0]            scoreA_o,
    output logic [2:0]            scoreB_o,
    output logic                  lastHit_o,
    output logic                  ootPress_o,
    output logic [1:0]            winner_o
);
    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_SHOW   = 3'd1;
    localparam logic [2:0] PH_ARM    = 3'd2;
    localparam logic [2:0] PH_ISSUE  = 3'd3;
    localparam logic [2:0] PH_WAIT   = 3'd4;
    localparam logic [2:0] PH_ERROR  = 3'd5;
    localparam logic [2:0] PH_RESULT = 3'd6;
    localparam logic [2:0] PH_WIN    = 3'd7;

    localparam logic [1:0] RSP_OK   = 2'b00;
    localparam logic [1:0] RSP_DUP  = 2'b01;
    localparam logic [1:0] RSP_HIT  = 2'b10;

    logic [2:0] phase_q, phase_d;
    logic [7:0] holdCnt_q, holdCnt_d;
    logic       battle_q, battle_d;
    logic       turn_q, turn_d;
    logic [2:0] placeCnt_q, placeCnt_d;
    logic [2:0] scoreA_q, scoreA_d;
    logic [2:0] scoreB_q, scoreB_d;
    logic       lastHit_q, lastHit_d;
    logic       ootPress_q, ootPress_d;
    logic [1:0] winner_q, winner_d;
    logic       cmdValid_q, cmdValid_d;
    logic       cmdOp_q, cmdOp_d;
    logic       cmdPlayer_q, cmdPlayer_d;
    logic [1:0] cmdX_q, cmdX_d;
    logic [1:0] cmdY_q, cmdY_d;
    logic       pAbPrev_q, pBbPrev_q;

    logic       pressA, pressB, pressTurn, pressOther, holdDone;
    logic [2:0] turnScore, placed;

    assign pressA     = pAb_i & ~pAbPrev_q;
    assign pressB     = pBb_i & ~pBbPrev_q;
    assign pressTurn  = turn_q ? pressB : pressA;
    assign pressOther = turn_q ? pressA : pressB;
    assign holdDone   = (holdCnt_q == 8'(HOLD_CYCLES - 1));
    assign turnScore  = turn_q ? scoreB_q : scoreA_q;
    assign placed     = placeCnt_q + 3'd1;

    always_comb begin
        phase_d     = phase_q;
        holdCnt_d   = 8'd0;
        battle_d    = battle_q;
        turn_d      = turn_q;
        placeCnt_d  = placeCnt_q;
        scoreA_d    = scoreA_q;
        scoreB_d    = scoreB_q;
        lastHit_d   = lastHit_q;
        ootPress_d  = 1'b0;
        winner_d    = winner_q;
        cmdValid_d  = cmdValid_q;
        cmdOp_d     = cmdOp_q;
        cmdPlayer_d = cmdPlayer_q;
        cmdX_d      = cmdX_q;
        cmdY_d      = cmdY_q;
        case (phase_q)
            PH_IDLE: begin
                if (start_i) begin
                    phase_d    = PH_SHOW;
                    turn_d     = 1'b0;
                    battle_d   = 1'b0;
                    placeCnt_d = 3'd0;
                end
            end
            PH_SHOW, PH_ERROR, PH_RESULT: begin
                if (!holdDone) begin
                    holdCnt_d = holdCnt_q + 8'd1;
                end else if (phase_q == PH_RESULT && turnScore == 3'(WIN_SCORE)) begin
                    phase_d  = PH_WIN;
                    winner_d = turn_q ? 2'b10 : 2'b01;
                end else begin
                    phase_d = PH_ARM;
                    if (phase_q == PH_RESULT) turn_d = ~turn_q;
                end
            end
            PH_ARM: begin
                // The turn player wins a simultaneous press; the other press still flags.
                ootPress_d = pressOther;
                if (pressTurn) begin
                    phase_d     = PH_ISSUE;
                    cmdValid_d  = 1'b1;
                    cmdOp_d     = battle_q;
                    cmdPlayer_d = turn_q;
                    cmdX_d      = x_i;
                    cmdY_d      = y_i;
                end
            end
            PH_ISSUE: begin
                if (cmdValid_q && bus.cmd_ready) begin
                    cmdValid_d = 1'b0;
                    phase_d    = PH_WAIT;
                end
            end
            PH_WAIT: begin
                if (bus.rsp_valid) begin
                    if (!battle_q) begin
                        if (bus.rsp_code == RSP_OK) begin
                            if (placed == 3'(SHIPS)) begin
                                placeCnt_d = 3'd0;
                                phase_d    = PH_SHOW;
                                turn_d     = ~turn_q;
                                if (turn_q) battle_d = 1'b1;
                            end else begin
                                placeCnt_d = placed;
                                phase_d    = PH_ARM;
                            end
                        end else begin
                            phase_d = PH_ERROR;
                        end
                    end else if (bus.rsp_code == RSP_HIT) begin
                        lastHit_d = 1'b1;
                        phase_d   = PH_RESULT;
                        if (turn_q) scoreB_d = scoreB_q + 3'd1;
                        else        scoreA_d = scoreA_q + 3'd1;
                    end else if (bus.rsp_code[1]) begin
                        lastHit_d = 1'b0;
                        phase_d   = PH_RESULT;
                    end else begin
                        phase_d = PH_ERROR;
                    end
                end
            end
            PH_WIN: begin
                phase_d = PH_WIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_IDLE;
            holdCnt_q   <= 8'd0;
            battle_q    <= 1'b0;
            turn_q      <= 1'b0;
            placeCnt_q  <= 3'd0;
            scoreA_q    <= 3'd0;
            scoreB_q    <= 3'd0;
            lastHit_q   <= 1'b0;
            ootPress_q  <= 1'b0;
            winner_q    <= 2'b00;
            cmdValid_q  <= 1'b0;
            cmdOp_q     <= 1'b0;
            cmdPlayer_q <= 1'b0;
            cmdX_q      <= 2'd0;
            cmdY_q      <= 2'd0;
            pAbPrev_q   <= 1'b0;
            pBbPrev_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            holdCnt_q   <= holdCnt_d;
            battle_q    <= battle_d;
            turn_q      <= turn_d;
            placeCnt_q  <= placeCnt_d;
            scoreA_q    <= scoreA_d;
            scoreB_q    <= scoreB_d;
            lastHit_q   <= lastHit_d;
            ootPress_q  <= ootPress_d;
            winner_q    <= winner_d;
            cmdValid_q  <= cmdValid_d;
            cmdOp_q     <= cmdOp_d;
            cmdPlayer_q <= cmdPlayer_d;
            cmdX_q      <= cmdX_d;
            cmdY_q      <= cmdY_d;
            pAbPrev_q   <= pAb_i;
            pBbPrev_q   <= pBb_i;
        end
    end

    assign bus.cmd_valid  = cmdValid_q;
    assign bus.cmd_op     = cmdOp_q;
    assign bus.cmd_player = cmdPlayer_q;
    assign bus.cmd_x      = cmdX_q;
    assign bus.cmd_y      = cmdY_q;
    assign phase_o        = phase_q;
    assign battle_o       = battle_q;
    assign turn_o         = turn_q;
    assign placeCnt_o     = placeCnt_q;
    assign scoreA_o       = scoreA_q;
    assign scoreB_o       = scoreB_q;
    assign lastHit_o      = lastHit_q;
    assign ootPress_o     = ootPress_q;
    assign winner_o       = winner_q;
endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Bench for battleship_turn_ctrl: plays one full game plus handshake, press and reset corner cases.
// Issued commands are matched against a queue of expected commands filled when presses are driven.
module tb_battleship_turn_ctrl;
    localparam int HOLD = 3;
    localparam logic [1:0] OK = 2'b00, DUP = 2'b01, HIT = 2'b10, MISS = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, pAb, pBb;
    logic [1:0] xIn, yIn;
    logic [2:0] phase, placeCnt, scoreA, scoreB;
    logic       battle, turn, lastHit, ootPress;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;
    logic [5:0] expQ[$];
    logic [5:0] expCmd;

    battleship_turn_ctrl_if bus();

    battleship_turn_ctrl #(.HOLD_CYCLES(HOLD), .SHIPS(4), .WIN_SCORE(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .start_i(start), .x_i(xIn), .y_i(yIn), .pAb_i(pAb), .pBb_i(pBb),
        .phase_o(phase), .battle_o(battle), .turn_o(turn), .placeCnt_o(placeCnt),
        .scoreA_o(scoreA), .scoreB_o(scoreB), .lastHit_o(lastHit),
        .ootPress_o(ootPress), .winner_o(winner)
    );

    always #5 clk = ~clk;

    // Any handshake about to complete on the next edge must match the oldest expected command.
    always @(negedge clk) begin
        #2;
        if (!rst && bus.cmd_valid && bus.cmd_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL cmd_unexpected: got %b expected none",
                         {bus.cmd_op, bus.cmd_player, bus.cmd_x, bus.cmd_y});
            end else begin
                expCmd = expQ.pop_front();
                if ({bus.cmd_op, bus.cmd_player, bus.cmd_x, bus.cmd_y} !== expCmd) begin
                    errors++;
                    $display("[TB] FAIL cmd_fields: got %b expected %b",
                             {bus.cmd_op, bus.cmd_player, bus.cmd_x, bus.cmd_y}, expCmd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyReset();
        rst = 1'b1; start = 1'b0; pAb = 1'b0; pBb = 1'b0; xIn = 2'd0; yIn = 2'd0;
        bus.cmd_ready = 1'b1; bus.rsp_valid = 1'b0; bus.rsp_code = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyPress(input logic op, input logic player, input logic [1:0] x, input logic [1:0] y);
        xIn = x; yIn = y;
        if (player) pBb = 1'b1; else pAb = 1'b1;
        expQ.push_back({op, player, x, y});
        @(negedge clk);
        pAb = 1'b0; pBb = 1'b0;
    endtask

    task automatic applyCommand(input logic op, input logic player, input logic [1:0] x,
                                input logic [1:0] y, input logic [1:0] code);
        applyPress(op, player, x, y);
        @(negedge clk);
        bus.rsp_valid = 1'b1; bus.rsp_code = code;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
    endtask

    task automatic waitHold();
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if (phase !== 3'd0) begin errors++; $display("[TB] FAIL reset_phase: got %0d expected 0", phase); end
        checks++;
        if ({bus.cmd_valid, battle, turn, placeCnt, scoreA, scoreB, lastHit, ootPress, winner} !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {bus.cmd_valid, battle, turn, placeCnt, scoreA, scoreB, lastHit, ootPress, winner});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (phase !== 3'd0) begin errors++; $display("[TB] FAIL idle_stay: got %0d expected 0", phase); end
    endtask

    task automatic test_start_hold();
        logic [2:0] exp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (phase !== 3'd1) begin errors++; $display("[TB] FAIL start_show: got %0d expected 1", phase); end
        for (int i = 1; i <= HOLD; i++) begin
            @(negedge clk);
            exp = (i < HOLD) ? 3'd1 : 3'd2;
            checks++;
            if (phase !== exp) begin errors++; $display("[TB] FAIL show_hold_%0d: got %0d expected %0d", i, phase, exp); end
            checks++;
            if ({battle, turn, placeCnt, bus.cmd_valid} !== 6'd0) begin
                errors++;
                $display("[TB] FAIL show_outputs_%0d: got %b expected 0", i, {battle, turn, placeCnt, bus.cmd_valid});
            end
        end
    endtask

    task automatic test_dup();
        logic [2:0] exp;
        applyCommand(1'b0, 1'b0, 2'd0, 2'd1, OK);
        checks++;
        if ({phase, placeCnt, turn} !== {3'd2, 3'd1, 1'b0}) begin
            errors++; $display("[TB] FAIL place1: got %b expected %b", {phase, placeCnt, turn}, {3'd2, 3'd1, 1'b0});
        end
        applyCommand(1'b0, 1'b0, 2'd1, 2'd1, DUP);
        checks++;
        if (phase !== 3'd5) begin errors++; $display("[TB] FAIL dup_error: got %0d expected 5", phase); end
        for (int i = 1; i <= HOLD; i++) begin
            @(negedge clk);
            exp = (i < HOLD) ? 3'd5 : 3'd2;
            checks++;
            if (phase !== exp) begin errors++; $display("[TB] FAIL dup_hold_%0d: got %0d expected %0d", i, phase, exp); end
        end
        checks++;
        if ({placeCnt, turn} !== {3'd1, 1'b0}) begin
            errors++; $display("[TB] FAIL dup_state: got %b expected %b", {placeCnt, turn}, {3'd1, 1'b0});
        end
        applyCommand(1'b0, 1'b0, 2'd2, 2'd1, MISS);
        checks++;
        if ({phase, placeCnt, scoreA, lastHit} !== {3'd5, 3'd1, 3'd0, 1'b0}) begin
            errors++; $display("[TB] FAIL wrong_mode_setup: got %b expected %b",
                               {phase, placeCnt, scoreA, lastHit}, {3'd5, 3'd1, 3'd0, 1'b0});
        end
        waitHold();
        checks++;
        if (phase !== 3'd2) begin errors++; $display("[TB] FAIL wrong_mode_exit: got %0d expected 2", phase); end
    endtask

    task automatic test_handshake();
        bus.cmd_ready = 1'b0;
        applyPress(1'b0, 1'b0, 2'd3, 2'd2);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({phase, bus.cmd_valid, bus.cmd_op, bus.cmd_player, bus.cmd_x, bus.cmd_y} !== {3'd3, 1'b1, 1'b0, 1'b0, 2'd3, 2'd2}) begin
                errors++;
                $display("[TB] FAIL stall_%0d: got %b expected %b", i,
                         {phase, bus.cmd_valid, bus.cmd_op, bus.cmd_player, bus.cmd_x, bus.cmd_y},
                         {3'd3, 1'b1, 1'b0, 1'b0, 2'd3, 2'd2});
            end
            @(negedge clk);
        end
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({phase, bus.cmd_valid} !== {3'd4, 1'b0}) begin
            errors++; $display("[TB] FAIL stall_release: got %b expected %b", {phase, bus.cmd_valid}, {3'd4, 1'b0});
        end
        bus.rsp_valid = 1'b1; bus.rsp_code = OK;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
        checks++;
        if ({phase, placeCnt} !== {3'd2, 3'd2}) begin
            errors++; $display("[TB] FAIL place2: got %b expected %b", {phase, placeCnt}, {3'd2, 3'd2});
        end
        pBb = 1'b1;
        @(negedge clk);
        pBb = 1'b0;
        checks++;
        if ({ootPress, phase} !== {1'b1, 3'd2}) begin
            errors++; $display("[TB] FAIL oot_pulse: got %b expected %b", {ootPress, phase}, {1'b1, 3'd2});
        end
        @(negedge clk);
        checks++;
        if ({ootPress, phase, bus.cmd_valid} !== {1'b0, 3'd2, 1'b0}) begin
            errors++; $display("[TB] FAIL oot_clear: got %b expected %b", {ootPress, phase, bus.cmd_valid}, {1'b0, 3'd2, 1'b0});
        end
    endtask

    task automatic test_setup();
        applyCommand(1'b0, 1'b0, 2'd1, 2'd0, OK);
        applyCommand(1'b0, 1'b0, 2'd2, 2'd2, OK);
        checks++;
        if ({phase, turn, placeCnt, battle} !== {3'd1, 1'b1, 3'd0, 1'b0}) begin
            errors++; $display("[TB] FAIL a_done: got %b expected %b", {phase, turn, placeCnt, battle}, {3'd1, 1'b1, 3'd0, 1'b0});
        end
        pAb = 1'b1; pBb = 1'b1;
        @(negedge clk);
        pAb = 1'b0; pBb = 1'b0;
        checks++;
        if ({ootPress, phase} !== {1'b0, 3'd1}) begin
            errors++; $display("[TB] FAIL hold_press: got %b expected %b", {ootPress, phase}, {1'b0, 3'd1});
        end
        repeat (HOLD - 1) @(negedge clk);
        checks++;
        if ({phase, bus.cmd_valid} !== {3'd2, 1'b0}) begin
            errors++; $display("[TB] FAIL b_arm: got %b expected %b", {phase, bus.cmd_valid}, {3'd2, 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            applyCommand(1'b0, 1'b1, 2'(i), 2'(3 - i), OK);
            if (i < 3) begin
                checks++;
                if ({phase, placeCnt, turn} !== {3'd2, 3'(i + 1), 1'b1}) begin
                    errors++; $display("[TB] FAIL b_place_%0d: got %b expected %b", i, {phase, placeCnt, turn}, {3'd2, 3'(i + 1), 1'b1});
                end
            end
        end
        checks++;
        if ({phase, battle, turn, placeCnt} !== {3'd1, 1'b1, 1'b0, 3'd0}) begin
            errors++; $display("[TB] FAIL b_done: got %b expected %b", {phase, battle, turn, placeCnt}, {3'd1, 1'b1, 1'b0, 3'd0});
        end
        waitHold();
    endtask

    task automatic test_both_press_held();
        applyCommand(1'b1, 1'b0, 2'd1, 2'd1, MISS);
        checks++;
        if ({phase, lastHit} !== {3'd6, 1'b0}) begin
            errors++; $display("[TB] FAIL a_miss: got %b expected %b", {phase, lastHit}, {3'd6, 1'b0});
        end
        waitHold();
        checks++;
        if ({phase, turn} !== {3'd2, 1'b1}) begin
            errors++; $display("[TB] FAIL turn_b: got %b expected %b", {phase, turn}, {3'd2, 1'b1});
        end
        xIn = 2'd3; yIn = 2'd3; pAb = 1'b1; pBb = 1'b1;
        expQ.push_back({1'b1, 1'b1, 2'd3, 2'd3});
        @(negedge clk);
        checks++;
        if ({phase, ootPress, bus.cmd_player, bus.cmd_op} !== {3'd3, 1'b1, 1'b1, 1'b1}) begin
            errors++; $display("[TB] FAIL both_press: got %b expected %b", {phase, ootPress, bus.cmd_player, bus.cmd_op}, {3'd3, 1'b1, 1'b1, 1'b1});
        end
        @(negedge clk);
        checks++;
        if ({phase, ootPress} !== {3'd4, 1'b0}) begin
            errors++; $display("[TB] FAIL both_once: got %b expected %b", {phase, ootPress}, {3'd4, 1'b0});
        end
        bus.rsp_valid = 1'b1; bus.rsp_code = MISS;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
        waitHold();
        @(negedge clk);
        checks++;
        if ({phase, turn, ootPress, bus.cmd_valid} !== {3'd2, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL held_single: got %b expected %b", {phase, turn, ootPress, bus.cmd_valid}, {3'd2, 1'b0, 1'b0, 1'b0});
        end
        pAb = 1'b0; pBb = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_battle_win();
        applyCommand(1'b1, 1'b0, 2'd0, 2'd0, OK);
        checks++;
        if ({phase, scoreA} !== {3'd5, 3'd0}) begin
            errors++; $display("[TB] FAIL wrong_mode_battle: got %b expected %b", {phase, scoreA}, {3'd5, 3'd0});
        end
        waitHold();
        for (int h = 1; h <= 4; h++) begin
            applyCommand(1'b1, 1'b0, 2'(h), 2'd2, HIT);
            checks++;
            if ({phase, scoreA, lastHit} !== {3'd6, 3'(h), 1'b1}) begin
                errors++; $display("[TB] FAIL hit_%0d: got %b expected %b", h, {phase, scoreA, lastHit}, {3'd6, 3'(h), 1'b1});
            end
            waitHold();
            if (h < 4) begin
                applyCommand(1'b1, 1'b1, 2'd0, 2'(h), MISS);
                checks++;
                if ({phase, scoreB, lastHit} !== {3'd6, 3'd0, 1'b0}) begin
                    errors++; $display("[TB] FAIL b_miss_%0d: got %b expected %b", h, {phase, scoreB, lastHit}, {3'd6, 3'd0, 1'b0});
                end
                waitHold();
            end
        end
        checks++;
        if ({phase, winner, scoreA} !== {3'd7, 2'b01, 3'd4}) begin
            errors++; $display("[TB] FAIL win: got %b expected %b", {phase, winner, scoreA}, {3'd7, 2'b01, 3'd4});
        end
        start = 1'b1; pAb = 1'b1; pBb = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0; pAb = 1'b0; pBb = 1'b0;
        @(negedge clk);
        checks++;
        if ({phase, winner, scoreA, ootPress, bus.cmd_valid} !== {3'd7, 2'b01, 3'd4, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL win_locked: got %b expected %b",
                               {phase, winner, scoreA, ootPress, bus.cmd_valid}, {3'd7, 2'b01, 3'd4, 1'b0, 1'b0});
        end
    endtask

    task automatic test_reset_issue();
        applyReset();
        checks++;
        if ({phase, winner, scoreA} !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_from_win: got %b expected 0", {phase, winner, scoreA});
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitHold();
        bus.cmd_ready = 1'b0;
        applyPress(1'b0, 1'b0, 2'd1, 2'd2);
        checks++;
        if ({phase, bus.cmd_valid} !== {3'd3, 1'b1}) begin
            errors++; $display("[TB] FAIL issue_before_rst: got %b expected %b", {phase, bus.cmd_valid}, {3'd3, 1'b1});
        end
        rst = 1'b1;
        @(negedge clk);
        expQ.delete();
        checks++;
        if ({phase, bus.cmd_valid} !== {3'd0, 1'b0}) begin
            errors++; $display("[TB] FAIL rst_in_issue: got %b expected %b", {phase, bus.cmd_valid}, {3'd0, 1'b0});
        end
        rst = 1'b0; bus.cmd_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_start_hold();
        test_dup();
        test_handshake();
        test_setup();
        test_both_press_held();
        test_battle_win();
        test_reset_issue();
        checks++;
        if (expQ.size() != 0) begin
            errors++; $display("[TB] FAIL leftover_cmds: got %0d expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
